// File: rtl/wb_pipe_stage.sv
// MEM->WB pipeline register with load alignment/extension and a saturating
// retire counter. Load data is aligned from the captured fields, so there is one cycle of latency.
module wb_pipe_stage #(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter int CNT_W        = 16,
  parameter int ZERO_DISCARD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_m,
  input  logic              reg_write_m,
  input  logic              mem_to_reg_m,
  input  logic [DATA_W-1:0] alu_out_m,
  input  logic [DATA_W-1:0] read_data_m,
  input  logic [REG_AW-1:0] write_reg_m,
  input  logic [1:0]        load_size_m,
  input  logic              load_signed_m,
  input  logic              stall_w,
  input  logic              flush_w,
  output logic              ready_m,
  output logic              valid_w,
  output logic              reg_write_w,
  output logic [REG_AW-1:0] write_reg_w,
  output logic [DATA_W-1:0] result_w,
  output logic [CNT_W-1:0]  retired_w
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic              valid_q, reg_write_q, mem_to_reg_q, load_signed_q;
  logic [DATA_W-1:0] alu_q, rdata_q;
  logic [REG_AW-1:0] wreg_q;
  logic [1:0]        lsize_q;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic              qual_m, accept;
  logic [OFF_W-1:0]  off, off_al;
  logic [DATA_W-1:0] shifted, load_ext;

  assign ready_m = !stall_w;
  assign accept  = !stall_w && !flush_w;
  assign qual_m  = valid_m && reg_write_m &&
                   !((ZERO_DISCARD != 0) && (write_reg_m == '0));

  always_comb begin
    retired_d = retired_q;
    if (accept && qual_m && !(&retired_q)) retired_d = retired_q + 1'b1;
  end

  // Halfword/word offsets are forced to natural alignment before the shift.
  always_comb begin
    off    = alu_q[OFF_W-1:0];
    off_al = off;
    case (lsize_q)
      2'b01:   off_al = off & ~OFF_W'(1);
      2'b10:   off_al = off & ~OFF_W'(3);
      default: off_al = off;
    endcase
    shifted  = rdata_q >> {off_al, 3'b000};
    load_ext = rdata_q;
    case (lsize_q)
      2'b00: begin
        load_ext       = {DATA_W{load_signed_q & shifted[7]}};
        load_ext[7:0]  = shifted[7:0];
      end
      2'b01: begin
        load_ext       = {DATA_W{load_signed_q & shifted[15]}};
        load_ext[15:0] = shifted[15:0];
      end
      2'b10: begin
        load_ext       = {DATA_W{load_signed_q & shifted[31]}};
        load_ext[31:0] = shifted[31:0];
      end
      default: load_ext = rdata_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      load_signed_q <= 1'b0;
      alu_q         <= '0;
      rdata_q       <= '0;
      wreg_q        <= '0;
      lsize_q       <= '0;
      retired_q     <= '0;
    end else if (flush_w) begin
      valid_q <= 1'b0;
    end else if (!stall_w) begin
      valid_q       <= valid_m;
      reg_write_q   <= reg_write_m;
      mem_to_reg_q  <= mem_to_reg_m;
      load_signed_q <= load_signed_m;
      alu_q         <= alu_out_m;
      rdata_q       <= read_data_m;
      wreg_q        <= write_reg_m;
      lsize_q       <= load_size_m;
      retired_q     <= retired_d;
    end
  end

  assign valid_w     = valid_q;
  assign reg_write_w = valid_q && reg_write_q &&
                       !((ZERO_DISCARD != 0) && (wreg_q == '0));
  assign write_reg_w = wreg_q;
  assign result_w    = mem_to_reg_q ? load_ext : alu_q;
  assign retired_w   = retired_q;
endmodule

// File: doc/wb_pipe_stage.md
WB_PIPE_STAGE -- requirements
Module: wb_pipe_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; SHALL be a multiple of 8 and at least 32.
REQ-002 Parameter REG_AW, default 5, register-address width.
REQ-003 Parameter CNT_W, default 16, width of the retire counter.
REQ-004 Parameter ZERO_DISCARD, default 1, suppresses writes to register 0 when 1.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 valid_m  in  1  MEM-stage entry valid.
REQ-008 reg_write_m  in  1  entry writes the register file.
REQ-009 mem_to_reg_m  in  1  result comes from load data, not the ALU.
REQ-010 alu_out_m  in  DATA_W  ALU result and load address.
REQ-011 read_data_m  in  DATA_W  raw memory word.
REQ-012 write_reg_m  in  REG_AW  destination register.
REQ-013 load_size_m  in  2  load size: 00 byte, 01 half, 10 word (32 bits), 11 full DATA_W.
REQ-014 load_signed_m  in  1  sign-extend when 1, zero-extend when 0.
REQ-015 stall_w  in  1  hold the stage.
REQ-016 flush_w  in  1  kill the incoming entry.
REQ-017 ready_m  out  1  stage accepts an entry this cycle.
REQ-018 valid_w  out  1  WB entry valid.
REQ-019 reg_write_w  out  1  qualified register-file write enable.
REQ-020 write_reg_w  out  REG_AW  destination register.
REQ-021 result_w  out  DATA_W  write-back value.
REQ-022 retired_w  out  CNT_W  saturating count of accepted qualifying writes.

Function
REQ-023 ready_m SHALL equal !stall_w, combinationally.
REQ-024 On a rising clk edge with stall_w=0 and flush_w=0, the stage SHALL capture all *_m fields; valid_w SHALL equal valid_m.
REQ-025 On a rising edge with flush_w=1, valid_w SHALL become 0 and the other registers SHALL hold; flush SHALL take priority over stall.
REQ-026 On a rising edge with stall_w=1 and flush_w=0, all registers SHALL hold.
REQ-027 Latency SHALL be one cycle: result_w SHALL reflect the entry captured at the most recent accepting edge, with no extra cycle of delay on either the ALU or the load path.
REQ-028 The load-data path SHALL use byte offset = captured alu_out bits [log2(DATA_W/8)-1:0].
REQ-029 For a byte load, the stage SHALL select the byte at that offset; for a half load, the halfword at the offset with bit 0 ignored; for a word load, the 32-bit word at the offset with bits [1:0] ignored.
REQ-030 The selected byte, half or word SHALL be extended to DATA_W, sign-extended if load_signed=1 and zero-extended otherwise.
REQ-031 For load_size 11, the full read_data SHALL be used unchanged.
REQ-032 result_w SHALL equal the extended load data when mem_to_reg=1, else the captured alu_out.
REQ-033 reg_write_w SHALL equal valid_w & reg_write & !(ZERO_DISCARD & write_reg==0).
REQ-034 retired_w SHALL increment by 1 on every accepting edge (stall_w=0, flush_w=0) where valid_m & reg_write_m & !(ZERO_DISCARD & write_reg_m==0).
REQ-035 retired_w SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-036 With valid_w=0, result_w and write_reg_w are don't-care but SHALL remain deterministic, holding the last captured values.

Reset
REQ-037 rst=1 SHALL asynchronously clear valid_w, reg_write_w, write_reg_w, result_w, retired_w and all internal captured fields to 0, independent of clk.
REQ-038 While rst=1, ready_m SHALL still follow !stall_w, and no capture or count SHALL occur.
REQ-039 Reset asserted mid-stall or mid-flush SHALL override both; the first accepting edge after release SHALL behave as REQ-024.

Verification
REQ-040 Reset: assert rst mid-cycle with retired_w=5 and valid_w=1 -> all outputs 0 before the next clk edge.
REQ-041 Signed byte load: alu_out_m=0x1003, read_data_m=0x80AA_BBCC, load_size_m=00, load_signed_m=1, mem_to_reg_m=1 -> result_w=0xFFFF_FF80 one cycle later; with load_signed_m=0 -> 0x0000_0080.
REQ-042 Half load: alu_out_m=0x2, read_data_m=0x1234_8765, unsigned -> result_w=0x0000_1234; signed with data 0x8001_0000 -> 0xFFFF_8001.
REQ-043 Stall/flush: capture write_reg_m=7, then stall_w=1 for 3 cycles with new inputs applied -> outputs unchanged and retired_w +1 total; then flush_w=1 with stall_w=1 -> valid_w=0 and reg_write_w=0.
REQ-044 Zero register: reg_write_m=1, write_reg_m=0, ZERO_DISCARD=1 -> reg_write_w=0 and retired_w unchanged; with ZERO_DISCARD=0 -> reg_write_w=1 and retired_w +1.
REQ-045 Saturation: CNT_W=2 with 5 consecutive qualifying writes -> retired_w sequence 1,2,3,3,3.
